// File: rtl/dmem_mmio_bridge.sv
// Data-memory MMIO bridge: LED register, cycle counter and optional UART TX at 0xFF0-0xFFF.
// Define MMIO_UART_EN to build the UART FIFO, transmitter FSM and status register.
module dmem_mmio_bridge #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [11:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q,
    output logic [15:0] led,
    output logic        uart_tx
);

    logic        mmio_hit;
    logic        mmio_wr;
    logic        sel;
    logic [31:0] periph_rd;
    logic [31:0] periph_q;
    logic [31:0] cycle_cnt;
    logic [3:0]  status;

    assign mmio_hit    = (address_dmem[11:4] == 8'hFF);
    assign mmio_wr     = wren && mmio_hit;
    assign mem_address = address_dmem;
    assign mem_data    = data;
    assign mem_wren    = wren && !mmio_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led <= '0;
        end else if (mmio_wr && address_dmem[3:0] == 4'h0) begin
            led <= data[15:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

`ifdef MMIO_UART_EN
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]  fifo [FIFO_DEPTH];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        ovf;
    logic        full;
    logic        empty;
    logic        push;
    logic        push_ok;
    logic        pop;
    logic [1:0]  state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        tx;
    logic        bit_done;

    // Full/overflow use the pre-pop count, so a push into a full FIFO drops even during a pop.
    assign full     = (count == 3'(FIFO_DEPTH));
    assign empty    = (count == 3'd0);
    assign push     = mmio_wr && address_dmem[3:0] == 4'h2;
    assign push_ok  = push && !full;
    assign pop      = (state == ST_IDLE) && !empty;
    assign bit_done = (clk_cnt == BIT_LAST);

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo[wr_ptr] <= data[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (mmio_wr && address_dmem[3:0] == 4'h3) begin
                ovf <= 1'b0;
            end else if (push && full) begin
                ovf <= 1'b1;
            end
        end
    end

    // The line output is registered from the current state, so it trails the state by one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                ST_START: tx <= 1'b0;
                ST_DATA:  tx <= shift[0];
                default:  tx <= 1'b1;
            endcase
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shift   <= fifo[rd_ptr];
                        clk_cnt <= '0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    assign status  = {ovf, state != ST_IDLE, empty, full};
    assign uart_tx = tx;
`else
    assign status  = '0;
    assign uart_tx = 1'b1;
`endif

    always_comb begin
        periph_rd = '0;
        case (address_dmem[3:0])
            4'h0:    periph_rd = {16'h0000, led};
            4'h1:    periph_rd = cycle_cnt;
            4'h3:    periph_rd = {28'h0, status};
            default: periph_rd = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel      <= 1'b0;
            periph_q <= '0;
        end else begin
            sel      <= mmio_hit;
            periph_q <= periph_rd;
        end
    end

    assign q_dmem = sel ? periph_q : mem_q;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Directed self-checking bench for dmem_mmio_bridge with a behavioural synchronous dmem.
// Expectations follow MMIO_UART_EN when it is defined for the build.
module tb_dmem_mmio_bridge;

    localparam int unsigned CPB = 4;
`ifdef MMIO_UART_EN
    localparam logic [31:0] IDLE_STATUS = 32'h2;
`else
    localparam logic [31:0] IDLE_STATUS = 32'h0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic [15:0] led;
    logic        uart_tx;

    logic [31:0] ram [0:4095];
    logic        smp [0:299];
    int          nrec;
    int          checks   = 0;
    int          failures = 0;

    dmem_mmio_bridge #(.CLKS_PER_BIT(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .mem_q        (mem_q),
        .led          (led),
        .uart_tx      (uart_tx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] <= mem_data;
        mem_q <= ram[mem_address];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic tick_rec;
        tick();
        if (nrec < 300) begin
            smp[nrec] = uart_tx;
            nrec++;
        end
    endtask

    task automatic set_bus(input logic [11:0] a, input logic [31:0] d, input logic w);
        address_dmem = a;
        data         = d;
        wren         = w;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        set_bus(12'h000, 32'h0, 1'b0);
        tick();
        tick();
        checks++;
        if (uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx got=%b exp=1", uart_tx);
        end
        checks++;
        if (led !== 16'h0) begin
            failures++;
            $display("FAIL reset_led got=%h exp=0000", led);
        end
        reset = 1'b1;
        set_bus(12'hFF3, 32'h0, 1'b0);
        tick();
        checks++;
        if (q_dmem !== IDLE_STATUS) begin
            failures++;
            $display("FAIL reset_status got=%h exp=%h", q_dmem, IDLE_STATUS);
        end
    endtask

    task automatic test_passthrough;
        logic [11:0] addrs [2];
        logic [31:0] vals  [2];
        addrs[0] = 12'h010; vals[0] = 32'h1234_5678;
        addrs[1] = 12'hFEF; vals[1] = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            set_bus(addrs[i], vals[i], 1'b1);
            #1;
            checks++;
            if (mem_wren !== 1'b1) begin
                failures++;
                $display("FAIL pass_wren_%0d got=%b exp=1", i, mem_wren);
            end
            tick();
            set_bus(addrs[i], 32'h0, 1'b0);
            #1;
            checks++;
            if (mem_wren !== 1'b0) begin
                failures++;
                $display("FAIL pass_wren_low_%0d got=%b exp=0", i, mem_wren);
            end
            tick();
            checks++;
            if (q_dmem !== vals[i]) begin
                failures++;
                $display("FAIL pass_read_%0d got=%h exp=%h", i, q_dmem, vals[i]);
            end
        end
        checks++;
        if (led !== 16'h0) begin
            failures++;
            $display("FAIL pass_led got=%h exp=0000", led);
        end
    endtask

    task automatic test_led;
        set_bus(12'hFF0, 32'hABCD_BEEF, 1'b1);
        #1;
        checks++;
        if (mem_wren !== 1'b0) begin
            failures++;
            $display("FAIL led_mem_wren got=%b exp=0", mem_wren);
        end
        tick();
        checks++;
        if (led !== 16'hBEEF) begin
            failures++;
            $display("FAIL led_value got=%h exp=beef", led);
        end
        set_bus(12'hFF0, 32'h0, 1'b0);
        tick();
        checks++;
        if (q_dmem !== 32'h0000_BEEF) begin
            failures++;
            $display("FAIL led_read got=%h exp=0000beef", q_dmem);
        end
    endtask

    task automatic test_unmapped;
        set_bus(12'hFF7, 32'h0000_1111, 1'b1);
        #1;
        checks++;
        if (mem_wren !== 1'b0) begin
            failures++;
            $display("FAIL unmapped_wren got=%b exp=0", mem_wren);
        end
        tick();
        checks++;
        if (led !== 16'hBEEF) begin
            failures++;
            $display("FAIL unmapped_led got=%h exp=beef", led);
        end
        set_bus(12'hFF7, 32'h0, 1'b0);
        tick();
        checks++;
        if (q_dmem !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_read_ff7 got=%h exp=0", q_dmem);
        end
        set_bus(12'hFFF, 32'h0, 1'b0);
        tick();
        checks++;
        if (q_dmem !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_read_fff got=%h exp=0", q_dmem);
        end
    endtask

    task automatic test_cycle;
        logic [31:0] c1;
        logic [31:0] c2;
        logic [31:0] exp;
        set_bus(12'hFF1, 32'h0, 1'b0);
        tick();
        c1 = q_dmem;
        set_bus(12'hFF1, 32'h0, 1'b1);
        tick();
        set_bus(12'h020, 32'h0, 1'b0);
        repeat (5) tick();
        set_bus(12'hFF1, 32'h0, 1'b0);
        tick();
        c2 = q_dmem;
        checks++;
        if (c2 - c1 !== 32'd7) begin
            failures++;
            $display("FAIL cycle_delta got=%0d exp=7", c2 - c1);
        end
        @(negedge clock);
        force dut.cycle_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.cycle_cnt;
        exp = 32'hFFFF_FFFD;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (q_dmem !== exp) begin
                failures++;
                $display("FAIL cycle_wrap_%0d got=%h exp=%h", k, q_dmem, exp);
            end
            exp = exp + 32'd1;
        end
    endtask

`ifdef MMIO_UART_EN
    task automatic test_uart_frame;
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        set_bus(12'hFF2, 32'h0000_00A5, 1'b1);
        tick();
        set_bus(12'hFF3, 32'h0, 1'b0);
        tick();
        checks++;
        if (uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL frame_pre_start got=%b exp=1", uart_tx);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (uart_tx !== frame[i / 4]) begin
                failures++;
                $display("FAIL frame_bit_%0d got=%b exp=%b", i, uart_tx, frame[i / 4]);
            end
            if (i == 20) begin
                checks++;
                if (q_dmem !== 32'h6) begin
                    failures++;
                    $display("FAIL frame_status_busy got=%h exp=6", q_dmem);
                end
            end
        end
        tick();
        checks++;
        if (uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL frame_post_idle got=%b exp=1", uart_tx);
        end
        checks++;
        if (q_dmem !== 32'h2) begin
            failures++;
            $display("FAIL frame_status_done got=%h exp=2", q_dmem);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] burst [5];
        logic [7:0] want  [5];
        logic [7:0] got   [8];
        int         starts [8];
        int         nframes;
        int         i;
        logic       prev;
        logic [7:0] rx;
        logic       stop_ok;
        burst[0] = 8'h22; burst[1] = 8'h33; burst[2] = 8'h44; burst[3] = 8'h55; burst[4] = 8'h66;
        want[0]  = 8'h11; want[1]  = 8'h22; want[2]  = 8'h33; want[3]  = 8'h44; want[4]  = 8'h55;
        nrec = 0;
        set_bus(12'hFF2, 32'h0000_0011, 1'b1);
        tick_rec();
        set_bus(12'hFF3, 32'h0, 1'b0);
        tick_rec();
        tick_rec();
        for (int b = 0; b < 5; b++) begin
            set_bus(12'hFF2, {24'h0, burst[b]}, 1'b1);
            tick_rec();
        end
        set_bus(12'hFF3, 32'h0, 1'b0);
        tick_rec();
        checks++;
        if (q_dmem !== 32'hD) begin
            failures++;
            $display("FAIL ovf_status got=%h exp=d", q_dmem);
        end
        set_bus(12'hFF3, 32'h0, 1'b1);
        tick_rec();
        set_bus(12'hFF3, 32'h0, 1'b0);
        tick_rec();
        checks++;
        if (q_dmem !== 32'h5) begin
            failures++;
            $display("FAIL ovf_clear got=%h exp=5", q_dmem);
        end
        set_bus(12'h020, 32'h0, 1'b0);
        while (nrec < 280) tick_rec();

        nframes = 0;
        stop_ok = 1'b1;
        prev    = 1'b1;
        i       = 0;
        while (i < 280) begin
            if (smp[i] == 1'b0 && prev == 1'b1) begin
                rx = '0;
                if (i + 40 <= 280) begin
                    for (int j = 0; j < 8; j++) rx[j] = smp[i + 4 * (j + 1) + 1];
                    if (smp[i + 37] !== 1'b1) stop_ok = 1'b0;
                end
                if (nframes < 8) begin
                    got[nframes]    = rx;
                    starts[nframes] = i;
                end
                nframes++;
                prev = smp[i + 39 < 280 ? i + 39 : 279];
                i    = i + 40;
            end else begin
                prev = smp[i];
                i++;
            end
        end
        checks++;
        if (nframes !== 5) begin
            failures++;
            $display("FAIL ovf_frame_count got=%0d exp=5", nframes);
        end
        for (int f = 0; f < 5; f++) begin
            if (f < nframes) begin
                checks++;
                if (got[f] !== want[f]) begin
                    failures++;
                    $display("FAIL ovf_byte_%0d got=%h exp=%h", f, got[f], want[f]);
                end
            end
        end
        checks++;
        if (stop_ok !== 1'b1) begin
            failures++;
            $display("FAIL ovf_stop_bits got=%b exp=1", stop_ok);
        end
        if (nframes >= 2) begin
            checks++;
            if (starts[1] - starts[0] !== 41) begin
                failures++;
                $display("FAIL frame_spacing got=%0d exp=41", starts[1] - starts[0]);
            end
        end
        set_bus(12'hFF3, 32'h0, 1'b0);
        tick();
        checks++;
        if (q_dmem !== 32'h2) begin
            failures++;
            $display("FAIL ovf_final_status got=%h exp=2", q_dmem);
        end
        set_bus(12'hFF2, 32'h0, 1'b0);
        tick();
        checks++;
        if (q_dmem !== 32'h0) begin
            failures++;
            $display("FAIL uart_data_read got=%h exp=0", q_dmem);
        end
    endtask

    task automatic test_reset_mid_frame;
        int zeros;
        set_bus(12'hFF2, 32'h0000_0000, 1'b1);
        tick();
        set_bus(12'hFF2, 32'h0000_003C, 1'b1);
        tick();
        set_bus(12'hFF2, 32'h0000_00C3, 1'b1);
        tick();
        set_bus(12'h020, 32'h0, 1'b0);
        repeat (8) tick();
        checks++;
        if (uart_tx !== 1'b0) begin
            failures++;
            $display("FAIL midframe_pre got=%b exp=0", uart_tx);
        end
        reset = 1'b0;
        #2;
        checks++;
        if (uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL midframe_async_tx got=%b exp=1", uart_tx);
        end
        tick();
        reset = 1'b1;
        set_bus(12'hFF3, 32'h0, 1'b0);
        tick();
        checks++;
        if (q_dmem !== 32'h2) begin
            failures++;
            $display("FAIL midframe_status got=%h exp=2", q_dmem);
        end
        set_bus(12'h020, 32'h0, 1'b0);
        zeros = 0;
        repeat (100) begin
            tick();
            if (uart_tx !== 1'b1) zeros++;
        end
        checks++;
        if (zeros !== 0) begin
            failures++;
            $display("FAIL midframe_no_resend got=%0d low cycles exp=0", zeros);
        end
    endtask
`else
    task automatic test_uart_disabled;
        int zeros;
        set_bus(12'hFF2, 32'h0000_00A5, 1'b1);
        #1;
        checks++;
        if (mem_wren !== 1'b0) begin
            failures++;
            $display("FAIL nouart_push_wren got=%b exp=0", mem_wren);
        end
        tick();
        set_bus(12'hFF3, 32'h0000_000F, 1'b1);
        #1;
        checks++;
        if (mem_wren !== 1'b0) begin
            failures++;
            $display("FAIL nouart_status_wren got=%b exp=0", mem_wren);
        end
        tick();
        set_bus(12'hFF2, 32'h0, 1'b0);
        tick();
        checks++;
        if (q_dmem !== 32'h0) begin
            failures++;
            $display("FAIL nouart_read_ff2 got=%h exp=0", q_dmem);
        end
        set_bus(12'hFF3, 32'h0, 1'b0);
        tick();
        checks++;
        if (q_dmem !== 32'h0) begin
            failures++;
            $display("FAIL nouart_read_ff3 got=%h exp=0", q_dmem);
        end
        set_bus(12'h020, 32'h0, 1'b0);
        zeros = 0;
        repeat (60) begin
            tick();
            if (uart_tx !== 1'b1) zeros++;
        end
        checks++;
        if (zeros !== 0) begin
            failures++;
            $display("FAIL nouart_tx_idle got=%0d low cycles exp=0", zeros);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_led();
        test_unmapped();
        test_cycle();
`ifdef MMIO_UART_EN
        test_uart_frame();
        test_overflow();
        test_reset_mid_frame();
`else
        test_uart_disabled();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
